// File: rtl/paridade_arbiter.sv
`default_nettype none
// ============================================================================
// paridade_arbiter : round-robin shared parity unit with tagged valid/ready
// response channel.  Revision 1.0
// ============================================================================
module paridade_arbiter #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] data,
   input  logic                  odd_mode,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_par
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
   logic              rsp_par_q, rsp_par_d;
   logic              odd_q, odd_d;

   logic [NREQ-1:0]   rot;
   logic              found;
   logic [IDW-1:0]    off;
   logic [IDW:0]      sum;
   logic [IDW-1:0]    sel;
   logic [WIDTH-1:0]  sel_word;

   // Rotate so bit 0 is the requester at ptr; the first set bit is the offset.
   always_comb begin
      rot   = NREQ'({req, req} >> ptr_q);
      found = 1'b0;
      off   = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!found && rot[j]) begin
            found = 1'b1;
            off   = IDW'(j);
         end
      end
      sum = {1'b0, ptr_q} + {1'b0, off};
      if (sum >= (IDW+1)'(NREQ)) begin
         sum = sum - (IDW+1)'(NREQ);
      end
      sel = sum[IDW-1:0];
   end

   always_comb begin
      sel_word = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (sel == IDW'(j)) begin
            sel_word = data[j*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gnt_d      = '0;
      rsp_id_d   = rsp_id_q;
      rsp_data_d = rsp_data_q;
      rsp_par_d  = rsp_par_q;
      odd_d      = odd_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d      = NREQ'(1) << sel;
               rsp_id_d   = sel;
               rsp_data_d = sel_word;
               odd_d      = odd_mode;
               state_d    = CALC;
            end
         end
         CALC: begin
            rsp_par_d = (^rsp_data_q) ^ odd_q;
            state_d   = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               ptr_d   = (rsp_id_q == IDW'(NREQ-1)) ? '0 : rsp_id_q + IDW'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         gnt_q      <= '0;
         rsp_id_q   <= '0;
         rsp_data_q <= '0;
         rsp_par_q  <= 1'b0;
         odd_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gnt_q      <= gnt_d;
         rsp_id_q   <= rsp_id_d;
         rsp_data_q <= rsp_data_d;
         rsp_par_q  <= rsp_par_d;
         odd_q      <= odd_d;
      end
   end

   assign gnt       = gnt_q;
   assign busy      = (state_q != IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_par   = rsp_par_q;

endmodule
`default_nettype wire

// File: tb/tb_paridade_arbiter.sv
`default_nettype none
// ============================================================================
// tb_paridade_arbiter : directed table-driven bench for paridade_arbiter.
// Revision 1.0
// ============================================================================
module tb_paridade_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] data;
   logic        odd_mode;
   logic [3:0]  gnt;
   logic        busy;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [3:0]  rsp_data;
   logic        rsp_par;

   int passed = 0;
   int total  = 0;

   paridade_arbiter #(.WIDTH(4), .NREQ(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .data      (data),
      .odd_mode  (odd_mode),
      .gnt       (gnt),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_par   (rsp_par)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [15:0] data;
      logic        odd;
      logic [1:0]  id;
      logic [3:0]  word;
      logic        par;
   } vec_t;

   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act === exp_v) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
   endtask

   // One full transaction starting from IDLE with rsp_ready high.
   task automatic run_vec(input vec_t v);
      req = v.req; data = v.data; odd_mode = v.odd; rsp_ready = 1'b1;
      tick();
      check("vec_gnt",  32'(gnt),  32'(4'b0001 << v.id));
      check("vec_busy", 32'(busy), 32'(1'b1));
      check("vec_calc_valid", 32'(rsp_valid), 32'(1'b0));
      req = '0; data = 16'h0000; odd_mode = ~v.odd;
      tick();
      check("vec_valid", 32'(rsp_valid), 32'(1'b1));
      check("vec_id",    32'(rsp_id),    32'(v.id));
      check("vec_data",  32'(rsp_data),  32'(v.word));
      check("vec_par",   32'(rsp_par),   32'(v.par));
      check("vec_gnt_low", 32'(gnt), 32'(4'b0000));
      tick();
      check("vec_valid_low", 32'(rsp_valid), 32'(1'b0));
      check("vec_busy_low",  32'(busy),      32'(1'b0));
   endtask

   initial begin
      vec_t       v;
      logic [3:0] w;

      // ptr starts at 0; each row's id follows from the rotation left by the previous row.
      vecs[0] = '{4'b0010, 16'h00B0, 1'b0, 2'd1, 4'b1011, 1'b1};
      vecs[1] = '{4'b0001, 16'h0006, 1'b1, 2'd0, 4'b0110, 1'b1};
      vecs[2] = '{4'b0001, 16'h0007, 1'b1, 2'd0, 4'b0111, 1'b0};
      vecs[3] = '{4'b1001, 16'hC001, 1'b0, 2'd3, 4'b1100, 1'b0};
      vecs[4] = '{4'b1001, 16'hC001, 1'b0, 2'd0, 4'b0001, 1'b1};
      vecs[5] = '{4'b0110, 16'h0E00, 1'b1, 2'd1, 4'b0000, 1'b1};
      vecs[6] = '{4'b0110, 16'h0E00, 1'b0, 2'd2, 4'b1110, 1'b1};
      vecs[7] = '{4'b0001, 16'h000F, 1'b1, 2'd0, 4'b1111, 1'b1};

      rst = 1'b1; req = '0; data = '0; odd_mode = 1'b0; rsp_ready = 1'b1;
      tick(); tick();
      check("rst_gnt",   32'(gnt),       32'(4'b0000));
      check("rst_busy",  32'(busy),      32'(1'b0));
      check("rst_valid", 32'(rsp_valid), 32'(1'b0));
      check("rst_id",    32'(rsp_id),    32'(2'd0));
      check("rst_data",  32'(rsp_data),  32'(4'b0000));
      check("rst_par",   32'(rsp_par),   32'(1'b0));
      rst = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Round robin with all requesters held active, fresh pointer.
      rst = 1'b1; tick(); rst = 1'b0; tick();
      req = 4'b1111; data = 16'h4321; odd_mode = 1'b0; rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         w = 4'((k % 4) + 1);
         tick();
         check("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
         tick();
         check("rr_valid", 32'(rsp_valid), 32'(1'b1));
         check("rr_id",    32'(rsp_id),    32'(k % 4));
         check("rr_data",  32'(rsp_data),  32'(w));
         check("rr_par",   32'(rsp_par),   32'(^w));
         tick();
         check("rr_gap", 32'(rsp_valid), 32'(1'b0));
      end
      req = '0;

      // Backpressure; ptr is 1 after serving 0.
      req = 4'b0100; data = 16'h0A00; rsp_ready = 1'b0;
      tick();
      check("bp_gnt", 32'(gnt), 32'(4'b0100));
      req = 4'b0001; data = 16'h0005;
      tick();
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", 32'(rsp_valid), 32'(1'b1));
         check("bp_id",    32'(rsp_id),    32'(2'd2));
         check("bp_data",  32'(rsp_data),  32'(4'b1010));
         check("bp_par",   32'(rsp_par),   32'(1'b0));
         check("bp_busy",  32'(busy),      32'(1'b1));
         check("bp_nognt", 32'(gnt),       32'(4'b0000));
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("bp_release_valid", 32'(rsp_valid), 32'(1'b0));
      check("bp_release_busy",  32'(busy),      32'(1'b0));
      tick();
      check("bp_next_gnt", 32'(gnt), 32'(4'b0001));
      req = '0;
      tick();
      check("bp_next_id",   32'(rsp_id),   32'(2'd0));
      check("bp_next_data", 32'(rsp_data), 32'(4'b0101));
      tick();

      // Inputs change right after grant; ptr is 1.
      req = 4'b1000; data = 16'hF000; odd_mode = 1'b0;
      tick();
      check("chg_gnt", 32'(gnt), 32'(4'b1000));
      req = '0; data = 16'h1000; odd_mode = 1'b1;
      tick();
      check("chg_id",   32'(rsp_id),   32'(2'd3));
      check("chg_data", 32'(rsp_data), 32'(4'b1111));
      check("chg_par",  32'(rsp_par),  32'(1'b0));
      tick();

      // Serve requester 2 so ptr becomes 3, then stall requester 3 and reset.
      v = '{4'b0100, 16'h0100, 1'b0, 2'd2, 4'b0001, 1'b1};
      run_vec(v);
      req = 4'b1000; data = 16'h7000; odd_mode = 1'b0; rsp_ready = 1'b0;
      tick();
      req = '0;
      tick();
      check("ar_pre_valid", 32'(rsp_valid), 32'(1'b1));
      check("ar_pre_id",    32'(rsp_id),    32'(2'd3));
      #3 rst = 1'b1;
      #1;
      check("ar_valid", 32'(rsp_valid), 32'(1'b0));
      check("ar_busy",  32'(busy),      32'(1'b0));
      check("ar_gnt",   32'(gnt),       32'(4'b0000));
      check("ar_data",  32'(rsp_data),  32'(4'b0000));
      tick();
      rst = 1'b0;
      req = 4'b1010; data = 16'h3050; rsp_ready = 1'b1;
      tick();
      check("ar_gnt_after", 32'(gnt), 32'(4'b0010));
      req = '0;
      tick();
      check("ar_id_after",   32'(rsp_id),   32'(2'd1));
      check("ar_data_after", 32'(rsp_data), 32'(4'b0101));
      check("ar_par_after",  32'(rsp_par),  32'(1'b0));
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
